// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus shared by NUM_REQ requesters and the write-port arbiter.
// Handshake: requester i holds req_valid[i] and its payload stable until granted; a
// transfer happens on a clock edge where req_valid[i] & req_ready[i]; req_ready may
// depend on req_valid, never the other way round.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      hold;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a one-cycle
// registered write stage and read-port forwarding of the staged write.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  regfile_write_arbiter_if.slave req_if,
  input  logic [ADDR_W-1:0]    rd_addr_1,
  input  logic [ADDR_W-1:0]    rd_addr_2,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 fwd_hit_1,
  output logic                 fwd_hit_2,
  output logic [DATA_W-1:0]    fwd_data_1,
  output logic [DATA_W-1:0]    fwd_data_2,
  output logic [7:0]           drop_count
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [7:0]        drop_count_q, drop_count_d;

  logic [NUM_REQ-1:0] valid_eff;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [PTR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_data;
  int                 idx;

  // Grants are suppressed while held or while reset is asserted.
  assign valid_eff = req_if.req_valid & {NUM_REQ{~req_if.hold & reset_n}};

  always_comb begin
    grant     = '0;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && valid_eff[idx]) begin
        found      = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign grant_addr = req_if.req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign grant_data = req_if.req_data[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    drop_count_d = drop_count_q;
    if (found) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      // Writes to register 0 complete the handshake but never reach the file.
      if (grant_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = grant_addr;
        rf_wdata_d = grant_data;
      end else if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign req_if.req_ready = grant;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign drop_count = drop_count_q;

  assign fwd_hit_1  = rf_we_q && (rd_addr_1 == rf_waddr_q) && (rd_addr_1 != '0);
  assign fwd_hit_2  = rf_we_q && (rd_addr_2 == rf_waddr_q) && (rd_addr_2 != '0);
  assign fwd_data_1 = fwd_hit_1 ? rf_wdata_q : '0;
  assign fwd_data_2 = fwd_hit_2 ? rf_wdata_q : '0;
endmodule
